// File: rtl/sha256_pkg.sv
// SHA-256 shared types, round constants, initial hash value and bit functions.
package sha256_pkg;

  typedef logic [31:0] word_t;
  typedef word_t [7:0] state_t;  // [7]=a/H0 ... [0]=h/H7

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINAL,
    S_DONE
  } fsm_t;

  localparam state_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t big_sig0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sig1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round.
module sha256_round
  import sha256_pkg::*;
(
  input  state_t i_st,
  input  word_t  i_w,
  input  word_t  i_k,
  output state_t o_st
);

  word_t t1;
  word_t t2;

  // T1/T2 and the a..h shift; e picks up d+T1, a picks up T1+T2
  always_comb begin
    t1   = i_st[0] + big_sig1(i_st[3]) + ch(i_st[3], i_st[2], i_st[1]) + i_k + i_w;
    t2   = big_sig0(i_st[7]) + maj(i_st[7], i_st[6], i_st[5]);
    o_st = {t1 + t2, i_st[7], i_st[6], i_st[5], i_st[4] + t1, i_st[3], i_st[2], i_st[1]};
  end

endmodule

// File: rtl/sha256_compress_iter.sv
// Iterative SHA-256 compression engine, UNROLL rounds per clock, registered digest.
module sha256_compress_iter
  import sha256_pkg::*;
#(
  parameter int unsigned UNROLL      = 1,
  parameter int unsigned DIG_REG_OUT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_blk_valid,
  output logic         o_blk_ready,
  input  logic [511:0] i_block,
  input  logic [255:0] i_state,
  input  logic         i_use_iv,
  output logic         o_dig_valid,
  input  logic         i_dig_ready,
  output logic [255:0] o_digest,
  output logic [5:0]   o_round
);

  if (DIG_REG_OUT != 1 || !(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_param
    $error("sha256_compress_iter: unsupported UNROLL/DIG_REG_OUT");
  end

  fsm_t                    state_q, state_d;
  word_t [15:0]            w_q, w_d;
  state_t                  chain_q, chain_d;
  state_t                  work_q, work_d;
  state_t                  digest_q, digest_d;
  logic [5:0]              round_q, round_d;
  logic                    dig_valid_q, dig_valid_d;

  word_t [15:0]            w_exp;
  word_t [UNROLL-1:0]      w_rnd;
  word_t [UNROLL-1:0]      k_rnd;
  state_t                  rnd_out;

  // Message schedule for this cycle's rounds; a later round sees words expanded earlier in the same cycle
  always_comb begin
    logic [5:0] t;
    logic [3:0] idx;
    t     = '0;
    idx   = '0;
    w_exp = w_q;
    w_rnd = '0;
    k_rnd = '0;
    for (int unsigned j = 0; j < UNROLL; j++) begin
      t   = round_q + 6'(j);
      idx = t[3:0];
      if (t[5:4] == 2'b00) begin
        w_rnd[j] = w_exp[idx];
      end else begin
        // slot idx still holds W[t-16]; idx+1 holds W[t-15]
        w_rnd[j] = small_sig1(w_exp[idx - 4'd2]) + w_exp[idx - 4'd7]
                 + small_sig0(w_exp[idx + 4'd1]) + w_exp[idx];
        w_exp[idx] = w_rnd[j];
      end
      k_rnd[j] = K[t];
    end
  end

  for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
    state_t st_in;
    state_t st_out;
    if (j == 0) begin : g_first
      assign st_in = work_q;
    end else begin : g_next
      assign st_in = g_rnd[j-1].st_out;
    end
    sha256_round u_round (
      .i_st (st_in),
      .i_w  (w_rnd[j]),
      .i_k  (k_rnd[j]),
      .o_st (st_out)
    );
  end

  assign rnd_out = g_rnd[UNROLL-1].st_out;

  // Control FSM and datapath next-state
  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    chain_d     = chain_q;
    work_d      = work_q;
    digest_d    = digest_q;
    round_d     = round_q;
    dig_valid_d = dig_valid_q;
    case (state_q)
      S_IDLE: begin
        if (i_blk_valid) begin
          for (int unsigned i = 0; i < 16; i++) begin
            w_d[i] = i_block[511 - 32*i -: 32];
          end
          chain_d = i_use_iv ? IV : i_state;
          work_d  = i_use_iv ? IV : i_state;
          round_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        work_d = rnd_out;
        w_d    = w_exp;
        if ({1'b0, round_q} + 7'(UNROLL) == 7'd64) begin
          round_d = '0;
          state_d = S_FINAL;
        end else begin
          round_d = round_q + 6'(UNROLL);
        end
      end
      S_FINAL: begin
        for (int unsigned i = 0; i < 8; i++) begin
          digest_d[i] = chain_q[i] + work_q[i];
        end
        dig_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (i_dig_ready) begin
          dig_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      w_q         <= '0;
      chain_q     <= '0;
      work_q      <= '0;
      digest_q    <= '0;
      round_q     <= '0;
      dig_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      chain_q     <= chain_d;
      work_q      <= work_d;
      digest_q    <= digest_d;
      round_q     <= round_d;
      dig_valid_q <= dig_valid_d;
    end
  end

  assign o_blk_ready = (state_q == S_IDLE);
  assign o_dig_valid = dig_valid_q;
  assign o_digest    = digest_q;
  assign o_round     = (state_q == S_RUN) ? round_q : '0;

endmodule

// File: tb/tb_sha256_compress_iter.sv
// Self-checking bench: four engines (UNROLL 1,2,4,8) driven one after another.
module tb_sha256_compress_iter;
  import sha256_pkg::K;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0]        rst, blk_valid, use_iv, dig_ready, blk_ready, dig_valid;
  logic [3:0][511:0] block;
  logic [3:0][255:0] st_in, digest;
  logic [3:0][5:0]   round;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sha256_compress_iter #(.UNROLL(1 << g), .DIG_REG_OUT(1)) u_dut (
      .clk         (clk),
      .rst         (rst[g]),
      .i_blk_valid (blk_valid[g]),
      .o_blk_ready (blk_ready[g]),
      .i_block     (block[g]),
      .i_state     (st_in[g]),
      .i_use_iv    (use_iv[g]),
      .o_dig_valid (dig_valid[g]),
      .i_dig_ready (dig_ready[g]),
      .o_digest    (digest[g]),
      .o_round     (round[g])
    );
  end

  typedef struct {
    logic [511:0] blk;
    logic [255:0] st;
    logic         iv;
    logic [255:0] dig;
  } vec_t;

  vec_t  vt [4];
  string vn [4] = '{"abc", "empty", "two_b1", "two_b2"};
  int    n_vec = 0;
  int    n_err = 0;

  localparam logic [255:0] IV_REF = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                     32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  // Reference model: straight 64-entry schedule
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] tmp;
    tmp = {x, x} >> n;
    return tmp[31:0];
  endfunction

  function automatic logic [255:0] ref_sha(input logic [511:0] b, input logic [255:0] h);
    logic [31:0] w [64];
    logic [31:0] a, bb, c, d, e, f, g, hh, t1, t2, x, y;
    for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      x = w[i-15];
      y = w[i-2];
      w[i] = (ror(y, 17) ^ ror(y, 19) ^ (y >> 10)) + w[i-7] + (ror(x, 7) ^ ror(x, 18) ^ (x >> 3)) + w[i-16];
    end
    {a, bb, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & bb) ^ (a & c) ^ (bb & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = bb; bb = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + bb, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  task automatic chk(input string name, input int u, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s U=%0d got %h want %h", name, 1 << u, act, exp);
    end
  endtask

  // Wait for o_blk_ready at a falling edge, offer the block, then scramble inputs after the accept edge
  task automatic accept(input int u, input logic [511:0] b, input logic [255:0] s, input logic iv, output int at);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!blk_ready[u] && n < 300);
    if (!blk_ready[u]) chk("ready_timeout", u, 256'(blk_ready[u]), 256'd1);
    blk_valid[u] = 1'b1;
    block[u]     = b;
    st_in[u]     = s;
    use_iv[u]    = iv;
    @(posedge clk);
    #1;
    at           = cyc;
    blk_valid[u] = 1'b0;
    block[u]     = ~b;
    st_in[u]     = ~s;
    use_iv[u]    = ~iv;
  endtask

  // Count edges until o_dig_valid, checking o_round along the way
  task automatic wait_dig(input int u, output int lat, output logic rnd_ok);
    int U = 1 << u;
    int er;
    lat    = 0;
    rnd_ok = 1'b1;
    do begin
      @(posedge clk);
      #1;
      lat++;
      er = (lat < 64 / U) ? lat * U : 0;
      if (int'(round[u]) != er) rnd_ok = 1'b0;
    end while (!dig_valid[u] && lat < 300);
  endtask

  task automatic release_dig(input int u);
    dig_ready[u] = 1'b1;
    @(posedge clk);
    #1;
    dig_ready[u] = 1'b0;
    chk("rel_valid", u, 256'(dig_valid[u]), 256'd0);
    chk("rel_ready", u, 256'(blk_ready[u]), 256'd1);
  endtask

  task automatic run_vec(input int u, input int v);
    int   at, lat;
    logic ok;
    accept(u, vt[v].blk, vt[v].st, vt[v].iv, at);
    wait_dig(u, lat, ok);
    chk({vn[v], "_lat"}, u, 256'(lat), 256'(64 / (1 << u) + 1));
    chk({vn[v], "_round"}, u, 256'(ok), 256'd1);
    chk(vn[v], u, digest[u], vt[v].dig);
    release_dig(u);
  endtask

  initial begin
    int   at, lat, prev;
    logic ok, hold_ok, sp_ok;
    logic [511:0] rb;
    logic [255:0] rs;

    vt[0] = '{{32'h61626380, 448'h0, 32'h00000018}, 256'h0, 1'b1,
              256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad};
    vt[1] = '{{32'h80000000, 480'h0}, 256'h0, 1'b1,
              256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855};
    vt[2] = '{{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
               32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
               32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000}, 256'h0, 1'b1,
              256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a};
    vt[3] = '{{480'h0, 32'h000001c0},
              256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a, 1'b0,
              256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1};

    rst = '1; blk_valid = '0; use_iv = '0; dig_ready = '0; block = '0; st_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = '0;

    for (int u = 0; u < 4; u++) begin
      chk("rst_ready", u, 256'(blk_ready[u]), 256'd1);
      chk("rst_valid", u, 256'(dig_valid[u]), 256'd0);
      chk("rst_digest", u, digest[u], 256'd0);
      chk("rst_round", u, 256'(round[u]), 256'd0);
    end

    for (int u = 0; u < 4; u++) begin
      // directed vectors, including the two-block chain
      for (int v = 0; v < 4; v++) run_vec(u, v);

      // consumer stall in DONE with a competing block offered
      accept(u, vt[0].blk, vt[0].st, 1'b1, at);
      wait_dig(u, lat, ok);
      chk("stall_first", u, digest[u], vt[0].dig);
      blk_valid[u] = 1'b1; block[u] = vt[1].blk; use_iv[u] = 1'b1;
      hold_ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk);
        #1;
        if (digest[u] !== vt[0].dig || dig_valid[u] !== 1'b1 || blk_ready[u] !== 1'b0) hold_ok = 1'b0;
      end
      chk("stall_hold", u, 256'(hold_ok), 256'd1);
      dig_ready[u] = 1'b1;
      @(posedge clk);
      #1;
      dig_ready[u] = 1'b0;
      chk("stall_idle", u, 256'(blk_ready[u]), 256'd1);
      chk("stall_valid_lo", u, 256'(dig_valid[u]), 256'd0);
      @(posedge clk);
      #1;
      blk_valid[u] = 1'b0;
      chk("stall_taken", u, 256'(blk_ready[u]), 256'd0);
      wait_dig(u, lat, ok);
      chk("stall_lat", u, 256'(lat), 256'(64 / (1 << u) + 1));
      chk("stall_second", u, digest[u], vt[1].dig);
      release_dig(u);

      // reset at round 32
      accept(u, vt[0].blk, vt[0].st, 1'b1, at);
      repeat (32 / (1 << u)) @(posedge clk);
      #1;
      chk("mid_round", u, 256'(round[u]), 256'd32);
      rst[u] = 1'b1;
      @(posedge clk);
      #1;
      rst[u] = 1'b0;
      chk("mid_rst_valid", u, 256'(dig_valid[u]), 256'd0);
      chk("mid_rst_ready", u, 256'(blk_ready[u]), 256'd1);
      chk("mid_rst_digest", u, digest[u], 256'd0);
      run_vec(u, 0);

      // back-to-back random blocks, alternating IV and supplied state
      dig_ready[u] = 1'b1;
      prev  = 0;
      sp_ok = 1'b1;
      for (int n = 0; n < 100; n++) begin
        for (int i = 0; i < 16; i++) rb[32*i +: 32] = $urandom;
        for (int i = 0; i < 8; i++) rs[32*i +: 32] = $urandom;
        accept(u, rb, rs, n[0], at);
        if (n > 0 && at - prev != 64 / (1 << u) + 3) sp_ok = 1'b0;
        prev = at;
        wait_dig(u, lat, ok);
        chk("rand", u, digest[u], ref_sha(rb, n[0] ? IV_REF : rs));
      end
      chk("spacing", u, 256'(sp_ok), 256'd1);
      @(posedge clk);
      #1;
      dig_ready[u] = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
